// File: rtl/vpu_pkg.sv
// Shared types and constants for the VPU reduction datapath.
package vpu_pkg;

    typedef enum logic [1:0] {
        RED_SUM  = 2'd0,
        RED_MAX  = 2'd1,
        RED_MIN  = 2'd2,
        RED_RSVD = 2'd3
    } vpu_red_op_t;

    typedef enum logic {
        ACC_IDLE  = 1'b0,
        ACC_ACCUM = 1'b1
    } acc_state_t;

    localparam int VPU_ELEM_WIDTH = 16;

endpackage

// File: rtl/vpu_red_combine2.sv
// Two-operand reduction primitive shared by the tree nodes and the accumulator.
module vpu_red_combine2
    import vpu_pkg::*;
#(
    parameter int ELEM_WIDTH = VPU_ELEM_WIDTH
) (
    input  logic [1:0]            op,
    input  logic [ELEM_WIDTH-1:0] a,
    input  logic [ELEM_WIDTH-1:0] b,
    output logic [ELEM_WIDTH-1:0] y
);

    vpu_red_op_t op_e;
    assign op_e = vpu_red_op_t'(op);

    // NOTE: assign every always_comb output before any branch so no path can infer a latch.
    always_comb begin
        y = a + b;  // SUM and the reserved encoding both wrap modulo 2^ELEM_WIDTH
        case (op_e)
            RED_MAX: y = ($signed(a) > $signed(b)) ? a : b;
            RED_MIN: y = ($signed(a) < $signed(b)) ? a : b;
            default: ;
        endcase
    end

endmodule

// File: rtl/vpu_seq_reduce_unit.sv
// Multi-beat vector reduction: registered log2 tree per beat, then an accumulator FSM
// that folds beats into one scalar broadcast on the output.
module vpu_seq_reduce_unit
    import vpu_pkg::*;
#(
    parameter  int ELEM_CNT   = 16,
    parameter  int ELEM_WIDTH = VPU_ELEM_WIDTH,
    parameter  int MAX_BEATS  = 16,
    localparam int BW         = $clog2(MAX_BEATS + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_first,
    input  logic                           in_last,
    input  logic [1:0]                     in_op,
    input  logic [ELEM_CNT*ELEM_WIDTH-1:0] in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ELEM_CNT*ELEM_WIDTH-1:0] out_data,
    output logic [BW-1:0]                  out_beats,
    output logic                           err_o
);

    localparam int L  = $clog2(ELEM_CNT);
    localparam int DW = ELEM_CNT * ELEM_WIDTH;
    // All tree levels packed lane-wise into one vector: level lv starts at lane 2*(ELEM_CNT - lanes(lv)).
    localparam int TW      = (2 * ELEM_CNT - 1) * ELEM_WIDTH;
    localparam int TOP_OFF = (2 * ELEM_CNT - 2) * ELEM_WIDTH;

    logic                  advance, accept;
    vpu_red_op_t           in_op_e, eff_op, vec_op_d, vec_op_q;
    logic [TW-1:0]         tree_d, tree_q;
    logic [L:0]            vld_d, vld_q, fst_d, fst_q, lst_d, lst_q;
    vpu_red_op_t           op_d [L+1];
    vpu_red_op_t           op_q [L+1];
    acc_state_t            state_d, state_q;
    logic [ELEM_WIDTH-1:0] acc_d, acc_q, acc_comb, tree_top, res;
    vpu_red_op_t           acc_op_d, acc_op_q;
    logic [BW-1:0]         cnt_d, cnt_q, res_beats;
    logic                  emit, err_d, err_q;
    logic                  out_valid_d, out_valid_q;
    logic [DW-1:0]         out_data_d, out_data_q;
    logic [BW-1:0]         out_beats_d, out_beats_q;

    assign advance   = !out_valid_q || out_ready;
    assign accept    = in_valid && advance;
    assign in_ready  = advance;
    assign in_op_e   = vpu_red_op_t'(in_op);
    // Later beats inherit the op latched from the vector's first beat.
    assign eff_op    = in_first ? in_op_e : vec_op_q;
    assign tree_top  = tree_q[TOP_OFF +: ELEM_WIDTH];
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_beats = out_beats_q;
    assign err_o     = err_q;

    assign tree_d[DW-1:0] = in_data;

    for (genvar lv = 1; lv <= L; lv++) begin : g_lvl
        localparam int IN_OFF  = 2 * (ELEM_CNT - (ELEM_CNT >> (lv - 1)));
        localparam int OUT_OFF = 2 * (ELEM_CNT - (ELEM_CNT >> lv));
        for (genvar j = 0; j < (ELEM_CNT >> lv); j++) begin : g_node
            vpu_red_combine2 #(.ELEM_WIDTH(ELEM_WIDTH)) u_node (
                .op (op_q[lv-1]),
                .a  (tree_q[(IN_OFF + 2*j) * ELEM_WIDTH +: ELEM_WIDTH]),
                .b  (tree_q[(IN_OFF + 2*j + 1) * ELEM_WIDTH +: ELEM_WIDTH]),
                .y  (tree_d[(OUT_OFF + j) * ELEM_WIDTH +: ELEM_WIDTH])
            );
        end
    end

    vpu_red_combine2 #(.ELEM_WIDTH(ELEM_WIDTH)) u_acc_combine (
        .op (acc_op_q),
        .a  (acc_q),
        .b  (tree_top),
        .y  (acc_comb)
    );

    always_comb begin
        vec_op_d = vec_op_q;
        if (accept && in_first) vec_op_d = in_op_e;
        vld_d   = {vld_q[L-1:0], accept};
        fst_d   = {fst_q[L-1:0], in_first};
        lst_d   = {lst_q[L-1:0], in_last};
        op_d[0] = eff_op;
        for (int i = 1; i <= L; i++) op_d[i] = op_q[i-1];
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        acc_op_d  = acc_op_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        emit      = 1'b0;
        res       = acc_comb;
        res_beats = cnt_q;
        if (advance && vld_q[L]) begin
            if (op_q[L] == RED_RSVD) err_d = 1'b1;
            if (fst_q[L]) begin
                if (state_q == ACC_ACCUM) err_d = 1'b1;
                acc_d    = tree_top;
                acc_op_d = op_q[L];
                cnt_d    = BW'(1);
                if (lst_q[L]) begin
                    emit      = 1'b1;
                    res       = tree_top;
                    res_beats = BW'(1);
                    state_d   = ACC_IDLE;
                end else begin
                    state_d = ACC_ACCUM;
                end
            end else if (state_q == ACC_IDLE) begin
                err_d = 1'b1;
            end else begin
                acc_d = acc_comb;
                if (cnt_q >= BW'(MAX_BEATS)) err_d = 1'b1;
                else                         cnt_d = cnt_q + BW'(1);
                if (lst_q[L]) begin
                    emit      = 1'b1;
                    res_beats = cnt_d;
                    state_d   = ACC_IDLE;
                end
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_beats_d = out_beats_q;
        if (advance) begin
            out_valid_d = emit;
            if (emit) begin
                out_data_d  = {ELEM_CNT{res}};
                out_beats_d = res_beats;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_op_q <= RED_SUM;
            vld_q    <= '0;
            fst_q    <= '0;
            lst_q    <= '0;
            for (int i = 0; i <= L; i++) op_q[i] <= RED_SUM;
            state_q     <= ACC_IDLE;
            acc_q       <= '0;
            acc_op_q    <= RED_SUM;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_beats_q <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_beats_q <= out_beats_d;
            if (advance) begin
                vec_op_q <= vec_op_d;
                vld_q    <= vld_d;
                fst_q    <= fst_d;
                lst_q    <= lst_d;
                for (int i = 0; i <= L; i++) op_q[i] <= op_d[i];
                state_q  <= state_d;
                acc_q    <= acc_d;
                acc_op_q <= acc_op_d;
                cnt_q    <= cnt_d;
            end
        end
    end

    // NOTE: tree lanes are qualified by vld_q, so the wide datapath carries no reset.
    always_ff @(posedge clk) begin
        if (advance) tree_q <= tree_d;
    end

endmodule

// File: tb/tb_vpu_seq_reduce_unit.sv
// Directed bench for vpu_seq_reduce_unit at ELEM_CNT=16, ELEM_WIDTH=16, MAX_BEATS=16.
module tb_vpu_seq_reduce_unit;

    localparam int EC = 16;
    localparam int EW = 16;
    localparam int DW = EC * EW;
    localparam int BW = 5;

    logic          clk, rst;
    logic          in_valid, in_ready, in_first, in_last;
    logic [1:0]    in_op;
    logic [DW-1:0] in_data, out_data;
    logic          out_valid, out_ready, err_o;
    logic [BW-1:0] out_beats;

    int checks     = 0;
    int errors     = 0;
    int err_pulses = 0;
    logic [BW+DW-1:0] res_q [$];

    vpu_seq_reduce_unit #(.ELEM_CNT(EC), .ELEM_WIDTH(EW), .MAX_BEATS(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_op     (in_op),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_beats (out_beats),
        .err_o     (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Results are taken at the negedge, where the handshake values seen by the next posedge are settled.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) res_q.push_back({out_beats, out_data});
        if (err_o) err_pulses++;
    end

    function automatic logic [DW-1:0] ramp(input int start);
        logic [DW-1:0] v;
        for (int k = 0; k < EC; k++) v[k*EW +: EW] = 16'(start + k);
        return v;
    endfunction

    function automatic logic [DW-1:0] fill(input int val);
        logic [DW-1:0] v;
        for (int k = 0; k < EC; k++) v[k*EW +: EW] = 16'(val);
        return v;
    endfunction

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_beat(input logic f, input logic l, input logic [1:0] op, input logic [DW-1:0] d);
        int waited = 0;
        in_valid = 1'b1;
        in_first = f;
        in_last  = l;
        in_op    = op;
        in_data  = d;
        while (!in_ready && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL drive_beat: in_ready got %b required 1 within 200 cycles", in_ready);
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output logic [DW-1:0] d, output logic [BW-1:0] b);
        int waited = 0;
        logic [BW+DW-1:0] r;
        while (res_q.size() == 0 && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (res_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wait_result: got no result required one within 100 cycles");
            d = 'x;
            b = 'x;
        end else begin
            r = res_q.pop_front();
            d = r[DW-1:0];
            b = r[BW+DW-1:DW];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycles(3);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h required 0", out_data); end
        checks++; if (out_beats !== '0) begin errors++; $display("FAIL reset_out_beats: got %0d required 0", out_beats); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err_o: got %b required 0", err_o); end
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        cycles(1);
    endtask

    task automatic test_sum_latency();
        int n = 0;
        res_q.delete();
        drive_beat(1'b1, 1'b1, 2'd0, ramp(1));
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (n !== 5) begin errors++; $display("FAIL sum_latency: got %0d cycles required 5", n); end
        checks++; if (out_data !== {EC{16'd136}}) begin errors++; $display("FAIL sum_data: got %h required all lanes 0088", out_data); end
        checks++; if (out_beats !== 5'd1) begin errors++; $display("FAIL sum_beats: got %0d required 1", out_beats); end
        cycles(2);
        res_q.delete();
    endtask

    task automatic test_max();
        logic [DW-1:0] b2, d;
        logic [BW-1:0] b;
        int e0 = err_pulses;
        b2 = ramp(-5);
        b2[7*EW +: EW] = 16'd100;
        drive_beat(1'b1, 1'b0, 2'd1, ramp(-5));
        drive_beat(1'b0, 1'b0, 2'd0, b2);
        drive_beat(1'b0, 1'b1, 2'd2, fill(-1));
        wait_result(d, b);
        checks++; if (d !== {EC{16'd100}}) begin errors++; $display("FAIL max_data: got %h required all lanes 0064", d); end
        checks++; if (b !== 5'd3) begin errors++; $display("FAIL max_beats: got %0d required 3", b); end
        cycles(2);
        checks++; if (err_pulses - e0 !== 0) begin errors++; $display("FAIL max_err: got %0d pulses required 0", err_pulses - e0); end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] d;
        logic [BW-1:0] b;
        drive_beat(1'b1, 1'b1, 2'd0, fill(32'h7FFF));
        wait_result(d, b);
        checks++; if (d !== {EC{16'hFFF0}}) begin errors++; $display("FAIL wrap_data: got %h required all lanes fff0", d); end
        checks++; if (b !== 5'd1) begin errors++; $display("FAIL wrap_beats: got %0d required 1", b); end
    endtask

    task automatic test_reserved_op();
        logic [DW-1:0] d;
        logic [BW-1:0] b;
        int e0 = err_pulses;
        drive_beat(1'b1, 1'b1, 2'd3, ramp(1));
        wait_result(d, b);
        cycles(2);
        checks++; if (d !== {EC{16'd136}}) begin errors++; $display("FAIL rsvd_data: got %h required all lanes 0088", d); end
        checks++; if (err_pulses - e0 !== 1) begin errors++; $display("FAIL rsvd_err: got %0d pulses required 1", err_pulses - e0); end
    endtask

    task automatic test_protocol_errors();
        logic [DW-1:0] d;
        logic [BW-1:0] b;
        int e0 = err_pulses;
        drive_beat(1'b0, 1'b1, 2'd0, fill(1));
        cycles(10);
        checks++; if (res_q.size() !== 0) begin errors++; $display("FAIL idle_drop_out: got %0d results required 0", res_q.size()); end
        checks++; if (err_pulses - e0 !== 1) begin errors++; $display("FAIL idle_drop_err: got %0d pulses required 1", err_pulses - e0); end
        e0 = err_pulses;
        drive_beat(1'b1, 1'b0, 2'd0, fill(1));
        drive_beat(1'b1, 1'b0, 2'd0, fill(2));
        drive_beat(1'b0, 1'b1, 2'd0, fill(3));
        wait_result(d, b);
        cycles(2);
        checks++; if (d !== {EC{16'd80}}) begin errors++; $display("FAIL restart_data: got %h required all lanes 0050", d); end
        checks++; if (b !== 5'd2) begin errors++; $display("FAIL restart_beats: got %0d required 2", b); end
        checks++; if (err_pulses - e0 !== 1) begin errors++; $display("FAIL restart_err: got %0d pulses required 1", err_pulses - e0); end
    endtask

    task automatic test_saturate();
        logic [DW-1:0] d;
        logic [BW-1:0] b;
        int e0 = err_pulses;
        for (int i = 0; i < 17; i++) drive_beat(i == 0, i == 16, 2'd0, fill(1));
        wait_result(d, b);
        cycles(2);
        checks++; if (d !== {EC{16'd272}}) begin errors++; $display("FAIL sat_data: got %h required all lanes 0110", d); end
        checks++; if (b !== 5'd16) begin errors++; $display("FAIL sat_beats: got %0d required 16", b); end
        checks++; if (err_pulses - e0 !== 1) begin errors++; $display("FAIL sat_err: got %0d pulses required 1", err_pulses - e0); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d, held_d;
        logic [BW-1:0] b, held_b;
        logic          held_v = 1'b0;
        res_q.delete();
        out_ready = 1'b0;
        fork
            begin
                drive_beat(1'b1, 1'b0, 2'd0, fill(1));
                drive_beat(1'b0, 1'b1, 2'd0, fill(1));
                drive_beat(1'b1, 1'b1, 2'd1, ramp(0));
                drive_beat(1'b1, 1'b0, 2'd2, ramp(-8));
                drive_beat(1'b0, 1'b1, 2'd2, fill(5));
            end
            begin
                for (int c = 0; c < 10; c++) begin
                    @(posedge clk);
                    #1;
                    if (out_valid) begin
                        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b required 0", in_ready); end
                        if (held_v) begin
                            checks++;
                            if (out_data !== held_d || out_beats !== held_b) begin
                                errors++;
                                $display("FAIL stall_hold: got %h/%0d required %h/%0d", out_data, out_beats, held_d, held_b);
                            end
                        end
                        held_d = out_data;
                        held_b = out_beats;
                        held_v = 1'b1;
                    end
                end
                checks++; if (held_v !== 1'b1) begin errors++; $display("FAIL stall_valid: got out_valid %b required 1 during stall", held_v); end
                out_ready = 1'b1;
            end
        join
        wait_result(d, b);
        checks++; if (d !== {EC{16'd32}} || b !== 5'd2) begin errors++; $display("FAIL b2b_v1: got %h/%0d required lanes 0020/2", d, b); end
        wait_result(d, b);
        checks++; if (d !== {EC{16'd15}} || b !== 5'd1) begin errors++; $display("FAIL b2b_v2: got %h/%0d required lanes 000f/1", d, b); end
        wait_result(d, b);
        checks++; if (d !== {EC{16'hFFF8}} || b !== 5'd2) begin errors++; $display("FAIL b2b_v3: got %h/%0d required lanes fff8/2", d, b); end
        cycles(10);
        checks++; if (res_q.size() !== 0) begin errors++; $display("FAIL b2b_extra: got %0d extra results required 0", res_q.size()); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d;
        logic [BW-1:0] b;
        int e0;
        drive_beat(1'b1, 1'b0, 2'd0, fill(1));
        drive_beat(1'b0, 1'b0, 2'd0, fill(1));
        cycles(1);
        rst = 1'b1;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b required 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rstmid_out_data: got %h required 0", out_data); end
        cycles(2);
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b required 1", in_ready); end
        res_q.delete();
        e0 = err_pulses;
        drive_beat(1'b1, 1'b1, 2'd2, ramp(-3));
        wait_result(d, b);
        checks++; if (d !== {EC{16'hFFFD}} || b !== 5'd1) begin errors++; $display("FAIL rstmid_min: got %h/%0d required lanes fffd/1", d, b); end
        cycles(10);
        checks++; if (res_q.size() !== 0) begin errors++; $display("FAIL rstmid_extra: got %0d extra results required 0", res_q.size()); end
        checks++; if (err_pulses - e0 !== 0) begin errors++; $display("FAIL rstmid_err: got %0d pulses required 0", err_pulses - e0); end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        in_op     = 2'd0;
        in_data   = '0;
        out_ready = 1'b1;
        #1;
        test_reset();
        test_sum_latency();
        test_max();
        test_wrap();
        test_reserved_op();
        test_protocol_errors();
        test_saturate();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
